fma_operand_feeder: RTL

Operand-side partner of the FPU FMA unit. Buffers operand pairs pushed by a host into a small FIFO and serves them to the FMA one pair per FMA request, as a two-beat `float_0`/`float_1` transfer. Waits for the accumulated answer after the pair marked last, then holds it on a valid/ready result port. Sits between the host/register-file side and the FMA core.

---
 rtl/fma_operand_feeder_if.sv | 46 ++++
 rtl/fma_operand_feeder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fma_operand_feeder_if.sv
// Host, FMA and result signals of fma_operand_feeder bundled into one interface.
// slave = the feeder itself; master = whatever drives it (host, FMA core, bench).
interface fma_feeder_if #(parameter int FP = 32);
    logic          host_valid_in;
    logic          host_ready_out;
    logic [FP-1:0] host_float_0_in;
    logic [FP-1:0] host_float_1_in;
    logic          host_last_in;
    logic          fma_req_in;
    logic          fma_busy_in;
    logic [FP-1:0] float_0_out;
    logic [FP-1:0] float_1_out;
    logic          float_0_req_out;
    logic          float_1_req_out;
    logic          last_out;
    logic [FP-1:0] fma_answer_in;
    logic          fma_ready_answer_in;
    logic          fma_overflow_in;
    logic          fma_underflow_in;
    logic [FP-1:0] result_out;
    logic          result_overflow_out;
    logic          result_underflow_out;
    logic          result_valid_out;
    logic          result_ready_in;
    logic          busy_out;
    logic          error_out;
    logic [2:0]    state_out;

    modport slave (
        input  host_valid_in, host_float_0_in, host_float_1_in, host_last_in,
               fma_req_in, fma_busy_in, fma_answer_in, fma_ready_answer_in,
               fma_overflow_in, fma_underflow_in, result_ready_in,
        output host_ready_out, float_0_out, float_1_out, float_0_req_out,
               float_1_req_out, last_out, result_out, result_overflow_out,
               result_underflow_out, result_valid_out, busy_out, error_out, state_out
    );

    modport master (
        output host_valid_in, host_float_0_in, host_float_1_in, host_last_in,
               fma_req_in, fma_busy_in, fma_answer_in, fma_ready_answer_in,
               fma_overflow_in, fma_underflow_in, result_ready_in,
        input  host_ready_out, float_0_out, float_1_out, float_0_req_out,
               float_1_req_out, last_out, result_out, result_overflow_out,
               result_underflow_out, result_valid_out, busy_out, error_out, state_out
    );
endinterface

// File: rtl/fma_operand_feeder.sv
// Operand FIFO + two-beat dispatcher feeding the FMA core, with answer capture/hold.
// Optional answer watchdog enabled by defining FMA_FEEDER_TIMEOUT_EN.
module fma_operand_feeder #(
    parameter int FP      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    fma_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND_0 = 3'd1,
        S_SEND_1 = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    logic [2*FP:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    state_t        r_state;
    logic [FP-1:0] r_f0, r_f1, r_res;
    logic          r_ent_last, r_f0_req, r_f1_req, r_last;
    logic          r_valid, r_ovf, r_unf, r_err;

    logic w_full, w_empty, w_ready, w_push, w_pop, w_ans, w_to_hit;
    logic [2*FP:0] w_head;

    assign w_full  = (r_cnt == (AW+1)'(DEPTH));
    assign w_empty = (r_cnt == '0);
    // rst gates ready combinationally so it reads 0 for the whole reset window
    assign w_ready = rst && !w_full;
    assign w_push  = bus.host_valid_in && w_ready;
    assign w_ans   = bus.fma_ready_answer_in;
    // an answer arriving in IDLE is a violation and wins over a dispatch
    assign w_pop   = (r_state == S_IDLE) && !w_empty && bus.fma_req_in &&
                     !bus.fma_busy_in && !w_ans;
    assign w_head  = r_mem[r_rd];

`ifdef FMA_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_to_cnt <= '0;
        else if (r_state != S_WAIT) r_to_cnt <= '0;
        else                       r_to_cnt <= r_to_cnt + 1'b1;
    end
    assign w_to_hit = (r_state == S_WAIT) && (r_to_cnt == TW'(TIMEOUT - 1));
`else
    // watchdog compiled out: WAIT_ANSWER never expires
    assign w_to_hit = 1'b0 & (TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {bus.host_last_in, bus.host_float_1_in, bus.host_float_0_in};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr <= '0; r_rd <= '0; r_cnt <= '0;
            r_state <= S_IDLE;
            r_f0 <= '0; r_f1 <= '0; r_res <= '0;
            r_ent_last <= 1'b0; r_f0_req <= 1'b0; r_f1_req <= 1'b0; r_last <= 1'b0;
            r_valid <= 1'b0; r_ovf <= 1'b0; r_unf <= 1'b0; r_err <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase

            r_f0_req <= 1'b0;
            r_f1_req <= 1'b0;
            r_last   <= 1'b0;

            if (w_ans && r_state != S_WAIT && r_state != S_ERROR) begin
                r_state <= S_ERROR;
                r_err   <= 1'b1;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_pop) begin
                        r_f0       <= w_head[FP-1:0];
                        r_f1       <= w_head[2*FP-1:FP];
                        r_ent_last <= w_head[2*FP];
                        r_f0_req   <= 1'b1;
                        r_state    <= S_SEND_0;
                    end
                    S_SEND_0: begin
                        r_f1_req <= 1'b1;
                        r_last   <= r_ent_last;
                        r_state  <= S_SEND_1;
                    end
                    S_SEND_1: r_state <= r_ent_last ? S_WAIT : S_IDLE;
                    S_WAIT: begin
                        if (w_ans) begin
                            r_res   <= bus.fma_answer_in;
                            r_ovf   <= bus.fma_overflow_in;
                            r_unf   <= bus.fma_underflow_in;
                            r_valid <= 1'b1;
                            r_state <= S_HOLD;
                        end else if (w_to_hit) begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                    S_HOLD: if (bus.result_ready_in) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_ERROR;
                endcase
            end
        end
    end

    assign bus.host_ready_out       = w_ready;
    assign bus.float_0_out          = r_f0;
    assign bus.float_1_out          = r_f1;
    assign bus.float_0_req_out      = r_f0_req;
    assign bus.float_1_req_out      = r_f1_req;
    assign bus.last_out             = r_last;
    assign bus.result_out           = r_res;
    assign bus.result_overflow_out  = r_ovf;
    assign bus.result_underflow_out = r_unf;
    assign bus.result_valid_out     = r_valid;
    assign bus.busy_out             = (r_state != S_IDLE) || !w_empty;
    assign bus.error_out            = r_err;
    assign bus.state_out            = r_state;
endmodule
